// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline definitions for the skid-buffered stage:
// state encoding, default widths and the per-cycle load controls.
package pipe_stage_skid_pkg;

   localparam int DATA_W_DEF = 69;
   localparam int CTRL_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

   localparam logic [7:0] KILL_MASK_DEF = 8'h0F;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic ld_main;
      logic ld_skid;
      logic main_from_skid;
   } skid_ctl_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One held pipeline entry (payload + control).
// Loads on ld, clears synchronously on Rst.
module pipe_entry_reg #(
   parameter int W = 8
) (
   input  logic         Clk,
   input  logic         Rst,
   input  logic         ld,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] ent_q;
   logic [W-1:0] ent_d;

   // next contents: new word when loaded, otherwise hold
   always_comb begin
      ent_d = ent_q;
      if (ld) begin
         ent_d = d;
      end
   end

   // storage with synchronous clear
   always_ff @(posedge Clk) begin
      if (Rst) begin
         ent_q <= '0;
      end else begin
         ent_q <= ent_d;
      end
   end

   assign q = ent_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline register (MAIN + SKID).
// in_ready is registered so it never depends on out_ready.
module pipe_stage_skid
   import pipe_stage_skid_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter logic [CTRL_W-1:0] KILL_MASK =
      CTRL_W'(KILL_MASK_DEF),
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int EW = DATA_W + CTRL_W;

   skid_state_e state_q;
   skid_state_e state_d;
   logic        vld_q;
   logic        vld_d;
   logic        rdy_q;
   logic        rdy_d;
   skid_ctl_t   ctl;

   logic [EW-1:0] in_ent;
   logic [EW-1:0] main_d;
   logic [EW-1:0] main_q;
   logic [EW-1:0] skid_q;

   logic [CTRL_W-1:0] main_ctrl;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;

   logic push;
   logic pop;

   assign in_ready  = rdy_q & ~Rst;
   assign out_valid = vld_q;
   assign push      = in_valid & in_ready;
   assign pop       = vld_q & out_ready;
   assign in_ent    = {in_data, in_ctrl};

   // next state and entry loads; flush wins over push/pop
   always_comb begin
      state_d = state_q;
      ctl     = '0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         unique case (1'b1)
            state_q == ST_EMPTY: begin
               if (push) begin
                  state_d     = ST_FULL;
                  ctl.ld_main = 1'b1;
               end
            end
            state_q == ST_FULL: begin
               if (push && pop) begin
                  ctl.ld_main = 1'b1;
               end else if (push) begin
                  state_d     = ST_SKID;
                  ctl.ld_skid = 1'b1;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            state_q == ST_SKID: begin
               if (pop) begin
                  state_d            = ST_FULL;
                  ctl.ld_main        = 1'b1;
                  ctl.main_from_skid = 1'b1;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
      vld_d = (state_d != ST_EMPTY);
      rdy_d = (state_d != ST_SKID);
   end

   // state register with handshake outputs kept alongside
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= ST_EMPTY;
         vld_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         vld_q   <= vld_d;
         rdy_q   <= rdy_d;
      end
   end

   // MAIN refills from SKID when draining, else from input
   always_comb begin
      main_d = in_ent;
      if (ctl.main_from_skid) begin
         main_d = skid_q;
      end
   end

   pipe_entry_reg #(
      .W (EW)
   ) u_main (
      .Clk (Clk),
      .Rst (Rst),
      .ld  (ctl.ld_main),
      .d   (main_d),
      .q   (main_q)
   );

   pipe_entry_reg #(
      .W (EW)
   ) u_skid (
      .Clk (Clk),
      .Rst (Rst),
      .ld  (ctl.ld_skid),
      .d   (in_ent),
      .q   (skid_q)
   );

   // saturating count of stalled output cycles
   always_comb begin
      cnt_d = cnt_q;
      if (vld_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // stall counter register; flush does not touch it
   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stall_cnt = cnt_q;
   assign out_data  = main_q[EW-1:CTRL_W];
   assign main_ctrl = main_q[CTRL_W-1:0];
   assign out_ctrl  = vld_q ? main_ctrl
                            : (main_ctrl & ~KILL_MASK);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: stream, backpressure,
// flush, counter saturation and reset while in SKID.
module tb_pipe_stage_skid;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        in_valid;
   logic [68:0] in_data;
   logic [7:0]  in_ctrl;
   logic        flush;
   logic        out_ready;

   logic        in_ready;
   logic        out_valid;
   logic [68:0] out_data;
   logic [7:0]  out_ctrl;
   logic [15:0] stall_cnt;

   logic        in_ready_s;
   logic        out_valid_s;
   logic [68:0] out_data_s;
   logic [7:0]  out_ctrl_s;
   logic [3:0]  stall_cnt_s;

   int n_chk  = 0;
   int n_pass = 0;

   logic [68:0] dA, dB, dP, dQ, dC;

   always #5 Clk = ~Clk;

   pipe_stage_skid u_dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .stall_cnt (stall_cnt)
   );

   pipe_stage_skid #(
      .CNT_W (4)
   ) u_dut4 (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_s),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .flush     (flush),
      .out_valid (out_valid_s),
      .out_ready (out_ready),
      .out_data  (out_data_s),
      .out_ctrl  (out_ctrl_s),
      .stall_cnt (stall_cnt_s)
   );

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      dA = {32'hDEADBEEF, 32'h12345678, 5'h1A};
      dB = {32'hCAFEF00D, 32'h0BADC0DE, 5'h05};
      dP = {32'h11111111, 32'h22222222, 5'h03};
      dQ = {32'h33333333, 32'h44444444, 5'h04};
      dC = {32'h55555555, 32'h66666666, 5'h1F};

      Rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_ctrl   = '0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // reset
      step();
      step();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_stall", stall_cnt, 0);
      Rst = 1'b0;
      #1;
      chk("post_rst_in_ready", in_ready, 1);

      // streaming 1..10
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         in_data = 69'(i);
         in_ctrl = 8'h10 + 8'(i);
         step();
         chk("strm_valid", out_valid, 1);
         chk("strm_data", out_data, i);
         chk("strm_ctrl", out_ctrl, 8'h10 + 8'(i));
         chk("strm_in_ready", in_ready, 1);
      end
      in_valid = 1'b0;
      step();
      chk("strm_end_valid", out_valid, 0);
      chk("strm_end_ctrl", out_ctrl, 8'h10);
      chk("strm_end_data", out_data, 10);
      chk("strm_end_stall", stall_cnt, 0);

      // backpressure A,B
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = dA;
      in_ctrl   = 8'h3C;
      step();
      chk("bp_full_valid", out_valid, 1);
      chk("bp_full_data", out_data, dA);
      chk("bp_full_stall", stall_cnt, 0);
      in_data = dB;
      in_ctrl = 8'hC3;
      step();
      chk("bp_skid_in_ready", in_ready, 0);
      chk("bp_skid_data", out_data, dA);
      chk("bp_skid_ctrl", out_ctrl, 8'h3C);
      chk("bp_skid_stall", stall_cnt, 1);
      in_valid = 1'b0;
      step();
      chk("bp_hold_in_ready", in_ready, 0);
      chk("bp_hold_data", out_data, dA);
      chk("bp_hold_stall", stall_cnt, 2);
      out_ready = 1'b1;
      step();
      chk("bp_pop1_data", out_data, dB);
      chk("bp_pop1_ctrl", out_ctrl, 8'hC3);
      chk("bp_pop1_in_ready", in_ready, 1);
      chk("bp_pop1_stall", stall_cnt, 2);
      step();
      chk("bp_pop2_valid", out_valid, 0);
      chk("bp_pop2_data", out_data, dB);
      chk("bp_pop2_ctrl", out_ctrl, 8'hC0);

      // flush in SKID with push attempt
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = dP;
      in_ctrl   = 8'hFF;
      step();
      in_data = dQ;
      in_ctrl = 8'hEE;
      step();
      chk("fl_skid_in_ready", in_ready, 0);
      chk("fl_skid_stall", stall_cnt, 3);
      flush   = 1'b1;
      in_data = dC;
      in_ctrl = 8'h77;
      step();
      chk("fl_valid", out_valid, 0);
      chk("fl_in_ready", in_ready, 1);
      chk("fl_ctrl", out_ctrl, 8'hF0);
      chk("fl_data", out_data, dP);
      chk("fl_stall", stall_cnt, 4);
      step();
      chk("fl_push_valid", out_valid, 0);
      chk("fl_push_data", out_data, dP);
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      chk("fl_after_valid", out_valid, 0);
      chk("fl_after_data", out_data, dP);
      chk("fl_after_stall", stall_cnt, 4);

      // stall counter saturation
      Rst = 1'b1;
      step();
      Rst       = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 69'd5;
      in_ctrl   = 8'h05;
      step();
      in_valid = 1'b0;
      chk("sat_start16", stall_cnt, 0);
      chk("sat_start4", stall_cnt_s, 0);
      repeat (20) step();
      chk("sat_cnt16", stall_cnt, 20);
      chk("sat_cnt4", stall_cnt_s, 15);
      repeat (3) step();
      chk("sat_hold16", stall_cnt, 23);
      chk("sat_hold4", stall_cnt_s, 15);
      chk("sat_valid", out_valid_s, 1);
      chk("sat_data", out_data, 5);

      // reset while in SKID with flush
      in_valid = 1'b1;
      in_data  = 69'd6;
      in_ctrl  = 8'h06;
      step();
      chk("rs_skid_in_ready", in_ready, 0);
      chk("rs_skid_data", out_data, 5);
      Rst   = 1'b1;
      flush = 1'b1;
      #1;
      chk("rs_during_in_ready", in_ready, 0);
      step();
      Rst      = 1'b0;
      flush    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rs_valid", out_valid, 0);
      chk("rs_data", out_data, 0);
      chk("rs_ctrl", out_ctrl, 0);
      chk("rs_stall", stall_cnt, 0);
      chk("rs_stall4", stall_cnt_s, 0);
      chk("rs_in_ready", in_ready, 1);
      out_ready = 1'b1;
      step();
      chk("rs_after_valid", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
